// File: rtl/rom_burst_reader.sv
// rom_burst_reader: constant synchronous ROM with a burst-read engine.
// A request (start address, length) is streamed out one word per beat with
// valid/ready backpressure; the address wraps at DEPTH.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      burst request handshake
//   req_addr, req_len        burst start address and beat count (0 means 1)
//   abort                    synchronous burst cancel
//   rsp_valid/rsp_ready      response beat handshake
//   rsp_data, rsp_addr       ROM word and its address
//   rsp_last                 final beat of the burst
//   busy                     burst in progress
module rom_burst_reader #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  input  logic              abort,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q,     state_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic [LEN_W-1:0]  rem_q,       rem_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q,  rsp_addr_d;
  logic              rsp_last_q,  rsp_last_d;
  logic              slot_free;

  // ROM contents: (a*5 + 3) mod 2**DATA_W; the cast performs the modulo.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(32'(a) * 32'd5 + 32'd3);
  endfunction

  assign slot_free = !rsp_valid_q || rsp_ready;

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_last_d  = rsp_last_q;

    if (abort) begin
      // Cancel wins over both request acceptance and beat issue; data/addr hold.
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b0;
      rsp_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rsp_ready) rsp_valid_d = 1'b0;
          if (req_valid) begin
            state_d = ST_RUN;
            ptr_d   = req_addr;
            rem_d   = (req_len == '0) ? LEN_W'(1) : req_len;
          end
        end
        ST_RUN: begin
          if (slot_free) begin
            rsp_data_d  = rom_word(ptr_q);
            rsp_addr_d  = ptr_q;
            rsp_last_d  = (rem_q == LEN_W'(1));
            rsp_valid_d = 1'b1;
            ptr_d       = ptr_q + ADDR_W'(1);
            rem_d       = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Testbench for rom_burst_reader: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue-based model.
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_addr;
  logic [3:0] req_len;
  logic       req_ready;
  logic       abort;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [1:0] rsp_addr;
  logic       rsp_last;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  rom_burst_reader #(.DATA_W(4), .ADDR_W(2), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .abort(abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: a burst becomes a list of beats; the output slot pops them.
  typedef struct { int a; int d; bit l; } beat_t;
  beat_t pend[$];
  bit    m_busy, m_v, m_l;
  int    m_a, m_d;

  function automatic int word_of(int a);
    return (a * 5 + 3) % 16;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit    was_busy;
    int    n;
    beat_t b;
    if (rst) begin
      pend.delete();
      m_busy = 0; m_v = 0; m_l = 0; m_a = 0; m_d = 0;
    end else if (abort) begin
      pend.delete();
      m_busy = 0; m_v = 0; m_l = 0;
    end else begin
      was_busy = m_busy;
      if (was_busy) begin
        if (!m_v || rsp_ready) begin
          b = pend.pop_front();
          m_v = 1; m_a = b.a; m_d = b.d; m_l = b.l;
          if (pend.size() == 0) m_busy = 0;
        end
      end else begin
        if (rsp_ready) m_v = 0;
        if (req_valid) begin
          m_busy = 1;
          n = (req_len == 0) ? 1 : int'(req_len);
          for (int i = 0; i < n; i++) begin
            b.a = (int'(req_addr) + i) % 4;
            b.d = word_of(b.a);
            b.l = (i == n - 1);
            pend.push_back(b);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (rsp_valid !== m_v || busy !== m_busy || req_ready !== !m_busy ||
          rsp_data !== 4'(m_d) || rsp_addr !== 2'(m_a) || rsp_last !== m_l) begin
        n_fail++;
        $display("FAIL model t=%0t got v=%b busy=%b rdy=%b d=%0d a=%0d l=%b want v=%b busy=%b rdy=%b d=%0d a=%0d l=%b",
                 $time, rsp_valid, busy, req_ready, rsp_data, rsp_addr, rsp_last,
                 m_v, m_busy, !m_busy, m_d, m_a, m_l);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Packs visible beat as {valid,addr,data,last} for literal checks.
  function automatic int beat_word();
    return {rsp_valid, rsp_addr, rsp_data, rsp_last};
  endfunction

  function automatic int mk(int v, int a, int d, int l);
    return (v << 7) | (a << 5) | (d << 1) | l;
  endfunction

  task automatic request(input int a, input int len);
    req_valid = 1'b1; req_addr = 2'(a); req_len = 4'(len);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic scen2(input string tag);
    rsp_ready = 1'b1;
    request(2, 3);
    chk({tag, "_lat_valid"}, int'(rsp_valid), 0);
    chk({tag, "_lat_busy"}, int'(busy), 1);
    @(negedge clk); chk({tag, "_b0"}, beat_word(), mk(1, 2, 13, 0));
    @(negedge clk); chk({tag, "_b1"}, beat_word(), mk(1, 3, 2, 0));
    @(negedge clk); chk({tag, "_b2"}, beat_word(), mk(1, 0, 3, 1));
    chk({tag, "_busy_end"}, int'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_addr = 0; req_len = 0; abort = 0; rsp_ready = 0;
    #1;
    chk("rst_state", {rsp_valid, rsp_data, rsp_last, busy, req_ready}, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold", {rsp_valid, rsp_data, rsp_last, busy, req_ready}, 1);

    scen2("s2");

    // Backpressure holds the first beat.
    rsp_ready = 1'b0;
    request(0, 2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("s3_hold", beat_word(), mk(1, 0, 3, 0));
      if (i < 3) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); chk("s3_last", beat_word(), mk(1, 1, 8, 1));
    @(negedge clk);

    // Abort during the second beat.
    request(1, 4);
    @(negedge clk); chk("s4_b0", beat_word(), mk(1, 1, 8, 0));
    @(negedge clk); chk("s4_b1", beat_word(), mk(1, 2, 13, 0));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("s4_abort", {rsp_valid, req_ready, rsp_last}, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("s4_quiet", int'(rsp_valid), 0);
    end

    // Zero length, then a wrapping burst.
    request(3, 0);
    @(negedge clk); chk("s5_single", beat_word(), mk(1, 3, 2, 1));
    @(negedge clk);
    request(3, 6);
    begin
      int exp_d[6] = '{2, 3, 8, 13, 2, 3};
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("s5_wrap", beat_word(), mk(1, (3 + i) % 4, exp_d[i], (i == 5) ? 1 : 0));
      end
    end
    @(negedge clk);

    // Reset pulse between edges mid-burst.
    request(0, 8);
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("s6_rst", {rsp_valid, rsp_data, rsp_addr, rsp_last, busy, req_ready}, 1);
    #1 rst = 1'b0;
    @(negedge clk);
    scen2("s6");

    // Randomized traffic checked by the model.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_addr  = 2'($urandom_range(0, 3));
      req_len   = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 9) < 7);
      abort     = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    req_valid = 0; abort = 0; rsp_ready = 1;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
